// File: rtl/biu.sv
// biu: arbitrates I-cache and D-cache line traffic onto one edge-triggered memory port.
// Define BIU_TIMEOUT_EN to add a read watchdog that raises err and halts the unit.
`ifndef CMEM_LINE
`define CMEM_LINE 512
`endif

module biu #(
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [63:0]           ic_addr,
  input  logic                  ic_rd,
  output logic [`CMEM_LINE-1:0] ic_rdata,
  output logic                  ic_dv,
  input  logic [63:0]           dc_addr,
  input  logic [63:0]           dc_wdata,
  input  logic [1:0]            dc_len,
  input  logic                  dc_rd,
  input  logic                  dc_wr,
  output logic [`CMEM_LINE-1:0] dc_rdata,
  output logic                  dc_dv,
  output logic [63:0]           mem_addr,
  output logic [63:0]           mem_wdata,
  output logic [1:0]            mem_len,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [`CMEM_LINE-1:0] mem_rdata,
  input  logic                  mem_dv,
  output logic                  err
);

  // state | meaning
  // IDLE  | waiting for a request, grants on the edge it is seen
  // RD    | line read outstanding, mem_rd held until mem_dv
  // WR    | single-cycle store strobe
  // GAP   | both strobes low so the memory edge detector re-arms
  // HALT  | read watchdog expired, dead until reset
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam int LW = `CMEM_LINE;

  logic [2:0]    state_q, state_d;
  logic          last_dc_q, last_dc_d;
  logic          gnt_dc_q, gnt_dc_d;
  logic [63:0]   mem_addr_q, mem_addr_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_len_q, mem_len_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [LW-1:0] ic_rdata_q, ic_rdata_d;
  logic [LW-1:0] dc_rdata_q, dc_rdata_d;
  logic          ic_dv_q, ic_dv_d;
  logic          dc_dv_q, dc_dv_d;
  logic          err_q, err_d;
  logic          dc_req;
  logic          pick_dc;
  logic          timeout_hit;

`ifdef BIU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // down-counter loaded on RD entry; terminal count with no mem_dv is a timeout
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_RD && state_d == S_RD)
      cnt_d = CNT_W'(TIMEOUT - 1);
    else if (state_q == S_RD && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  assign timeout_hit = (state_q == S_RD) && !mem_dv && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  assign dc_req  = dc_rd | dc_wr;
  // on a tie, the requester not granted last wins
  assign pick_dc = dc_req && (!ic_rd || !last_dc_q);

  always_comb begin
    state_d     = state_q;
    last_dc_d   = last_dc_q;
    gnt_dc_d    = gnt_dc_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_len_d   = mem_len_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    ic_dv_d     = 1'b0;
    dc_dv_d     = 1'b0;
    err_d       = err_q | timeout_hit;

    case (state_q)
      S_IDLE: begin
        if (ic_rd || dc_req) begin
          gnt_dc_d   = pick_dc;
          last_dc_d  = pick_dc;
          mem_addr_d = pick_dc ? dc_addr : ic_addr;
          if (pick_dc && dc_wr) begin
            state_d     = S_WR;
            mem_wr_d    = 1'b1;
            mem_len_d   = dc_len;
            mem_wdata_d = dc_wdata;
          end else begin
            state_d   = S_RD;
            mem_rd_d  = 1'b1;
            mem_len_d = 2'b11;
          end
        end
      end
      S_RD: begin
        if (mem_dv) begin
          if (gnt_dc_q) begin
            dc_rdata_d = mem_rdata;
            dc_dv_d    = 1'b1;
          end else begin
            ic_rdata_d = mem_rdata;
            ic_dv_d    = 1'b1;
          end
          mem_rd_d = 1'b0;
          state_d  = S_GAP;
        end else if (timeout_hit) begin
          dc_dv_d  = gnt_dc_q;
          ic_dv_d  = !gnt_dc_q;
          mem_rd_d = 1'b0;
          state_d  = S_HALT;
        end
      end
      S_WR: begin
        mem_wr_d = 1'b0;
        dc_dv_d  = 1'b1;
        state_d  = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      S_HALT: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
      default: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_dc_q   <= 1'b0;
      gnt_dc_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_len_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_dv_q     <= 1'b0;
      dc_dv_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dc_q   <= last_dc_d;
      gnt_dc_q    <= gnt_dc_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_len_q   <= mem_len_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      ic_dv_q     <= ic_dv_d;
      dc_dv_q     <= dc_dv_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_len   = mem_len_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign ic_dv     = ic_dv_q;
  assign dc_dv     = dc_dv_q;
  assign err       = err_q;

endmodule

// File: tb/tb_biu.sv
// tb_biu: directed bench for biu with an edge-triggered line memory model.
`ifndef CMEM_LINE
`define CMEM_LINE 512
`endif

module tb_biu;
  localparam int LW = `CMEM_LINE;
  localparam int D  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   ic_addr, dc_addr, dc_wdata;
  logic          ic_rd, dc_rd, dc_wr;
  logic [1:0]    dc_len;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_rdata;
  logic          ic_dv, dc_dv, mem_dv, mem_rd, mem_wr, err;
  logic [63:0]   mem_addr, mem_wdata;
  logic [1:0]    mem_len;

  int n_tests = 0;
  int n_fail  = 0;
  bit mem_on  = 1'b1;

  biu #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_addr(ic_addr), .ic_rd(ic_rd), .ic_rdata(ic_rdata), .ic_dv(ic_dv),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_len(dc_len), .dc_rd(dc_rd), .dc_wr(dc_wr),
    .dc_rdata(dc_rdata), .dc_dv(dc_dv),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_len(mem_len),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_dv(mem_dv),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] pat(input int i);
    logic [LW-1:0] r;
    r = '0;
    for (int w = 0; w < LW/32; w++) r[w*32 +: 32] = {8'(i), 8'(w), 16'hC0DE};
    return r;
  endfunction

  // memory: 16 lines, acts on rising strobes, dv D edges after the rise is seen
  logic [LW-1:0] mem [0:15];
  logic rd_prev, wr_prev;
  int   wait_cnt = 0;

  always @(posedge clk) begin
    rd_prev <= mem_rd;
    wr_prev <= mem_wr;
    mem_dv  <= 1'b0;
    if (mem_rd && !rd_prev) wait_cnt <= D;
    else if (wait_cnt > 0) begin
      wait_cnt <= wait_cnt - 1;
      if (wait_cnt == 1 && mem_on) begin
        mem_dv    <= 1'b1;
        mem_rdata <= mem[mem_addr[9:6]];
      end
    end
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= pat(i);
    end else if (mem_wr && !wr_prev) begin : wr_blk
      automatic logic [LW-1:0] line = mem[mem_addr[9:6]];
      for (int b = 0; b < (1 << mem_len); b++)
        line[(int'(mem_addr[5:0]) + b)*8 +: 8] = mem_wdata[b*8 +: 8];
      mem[mem_addr[9:6]] <= line;
    end
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_read(input bit use_dc, input logic [63:0] addr,
                         input logic [LW-1:0] exp, input string tag);
    int t_mdv, t_dv;
    bit held;
    t_mdv = -1; t_dv = -1; held = 1'b1;
    if (use_dc) begin dc_addr = addr; dc_rd = 1'b1; end
    else        begin ic_addr = addr; ic_rd = 1'b1; end
    step();
    check({tag, "_strobe"}, LW'({mem_rd, mem_wr, mem_len}), LW'(4'b1011));
    check({tag, "_addr"}, LW'(mem_addr), LW'(addr));
    for (int k = 1; k <= 40 && t_dv < 0; k++) begin
      step();
      if (mem_dv && t_mdv < 0) t_mdv = k;
      if (use_dc ? dc_dv : ic_dv) t_dv = k;
      else if (!mem_rd) held = 1'b0;
    end
    check({tag, "_lat"}, LW'(t_dv), LW'(D + 2));
    check({tag, "_dv_after_mdv"}, LW'(t_dv - t_mdv), LW'(1));
    check({tag, "_rd_held"}, LW'(held), LW'(1));
    check({tag, "_gap"}, LW'({mem_rd, mem_wr}), '0);
    check({tag, "_data"}, use_dc ? dc_rdata : ic_rdata, exp);
    if (use_dc) dc_rd = 1'b0; else ic_rd = 1'b0;
    step();
    check({tag, "_dv_pulse"}, LW'({ic_dv, dc_dv}), '0);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] len, input string tag);
    dc_addr = addr; dc_wdata = wdata; dc_len = len; dc_wr = 1'b1;
    step();
    check({tag, "_strobe"}, LW'({mem_wr, mem_rd, dc_dv}), LW'(3'b100));
    check({tag, "_fields"}, LW'({mem_addr, mem_wdata, mem_len}), LW'({addr, wdata, len}));
    step();
    check({tag, "_dv"}, LW'({mem_wr, mem_rd, dc_dv}), LW'(3'b001));
    dc_wr = 1'b0;
    step();
    check({tag, "_end"}, LW'({mem_wr, dc_dv}), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] exp0, exp3, first_addr;
    int t_dc, t_ic, n_bad;
    bit gap_ok;

    rst_n = 1'b0; ic_rd = 1'b0; dc_rd = 1'b0; dc_wr = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; dc_len = '0;
    step(); step();
    check("rst_ctrl", LW'({mem_rd, mem_wr, ic_dv, dc_dv, err, mem_len}), '0);
    check("rst_addr", LW'({mem_addr, mem_wdata}), '0);
    check("rst_ic_rdata", ic_rdata, '0);
    check("rst_dc_rdata", dc_rdata, '0);
    rst_n = 1'b1;
    step();

    // contention straight out of reset: DC wins the first tie
    ic_addr = 64'h8000_0040; dc_addr = 64'h8000_0080; ic_rd = 1'b1; dc_rd = 1'b1;
    t_dc = -1; t_ic = -1; gap_ok = 1'b0;
    step();
    first_addr = LW'(mem_addr);
    for (int k = 1; k <= 60 && t_ic < 0; k++) begin
      step();
      if (dc_dv) begin t_dc = k; gap_ok = !mem_rd && !mem_wr; dc_rd = 1'b0; end
      if (ic_dv) begin t_ic = k; ic_rd = 1'b0; end
    end
    check("cont_first_dc", first_addr, LW'(64'h8000_0080));
    check("cont_dc_time", LW'(t_dc), LW'(5));
    check("cont_gap_low", LW'(gap_ok), LW'(1));
    check("cont_ic_time", LW'(t_ic), LW'(12));
    check("cont_dc_data", dc_rdata, pat(2));
    check("cont_ic_data", ic_rdata, pat(1));
    step();

    do_read(1'b0, 64'h8000_0000, pat(0), "ifetch");

    exp0 = pat(0);
    exp0[16*8 +: 64] = 64'h1122_3344_5566_7788;
    do_write(64'h8000_0010, 64'h1122_3344_5566_7788, 2'd3, "st");
    do_read(1'b1, 64'h8000_0010, exp0, "ld");

    exp3 = pat(3);
    exp3[0 +: 8]      = 8'hAB;
    exp3[8*8 +: 16]   = 16'hBEEF;
    exp3[16*8 +: 32]  = 32'hDEAD_BEEF;
    do_write(64'h8000_00C0, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0, "b2b0");
    do_write(64'h8000_00C8, 64'hFFFF_FFFF_FFFF_BEEF, 2'd1, "b2b1");
    do_write(64'h8000_00D0, 64'hFFFF_FFFF_DEAD_BEEF, 2'd2, "b2b2");
    do_read(1'b1, 64'h8000_00C0, exp3, "b2b_rd");

`ifdef BIU_TIMEOUT_EN
    begin
      int t_err, t_dvto, ndv;
      mem_on = 1'b0;
      t_err = -1; t_dvto = -1; ndv = 0;
      dc_addr = 64'h8000_0080; dc_rd = 1'b1;
      step();
      for (int k = 1; k <= 40; k++) begin
        step();
        if (err && t_err < 0) t_err = k;
        if (dc_dv) begin ndv++; t_dvto = k; end
        if (k == 17) dc_rd = 1'b0;
      end
      check("to_err_time", LW'(t_err), LW'(16));
      check("to_dv_time", LW'(t_dvto), LW'(16));
      check("to_dv_count", LW'(ndv), LW'(1));
      check("to_rdata_kept", dc_rdata, exp3);
      ic_addr = 64'h8000_0040; ic_rd = 1'b1; n_bad = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (mem_rd || mem_wr || ic_dv) n_bad++;
      end
      check("to_halt_quiet", LW'(n_bad), '0);
      check("to_err_sticky", LW'(err), LW'(1));
      ic_rd = 1'b0;
      mem_on = 1'b1;
    end
`else
    check("err_idle", LW'(err), '0);
`endif

    // reset three cycles into a read; the late mem_dv must be dropped
    ic_addr = 64'h8000_0040; ic_rd = 1'b1;
    step(); step(); step(); step();
    rst_n = 1'b0; ic_rd = 1'b0;
    #1;
    check("rmid_out", LW'({mem_rd, mem_wr, ic_dv, dc_dv, err, mem_len}), '0);
    check("rmid_addr", LW'(mem_addr), '0);
    #2 rst_n = 1'b1;
    n_bad = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ic_dv || dc_dv || mem_rd || mem_wr) n_bad++;
    end
    check("rmid_no_dv", LW'(n_bad), '0);
    check("rmid_ic_rdata", ic_rdata, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
